alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Issue/sequencing stage that sits directly upstream of the combinational alu and also captures its output.
- Accepts operation requests over a valid/ready interface and buffers them in a small FIFO.
- Drives the alu's enable/command/a/b ports from registers for exactly one cycle per operation.
- Captures alu result/overflow into a response register, presented over a valid/ready interface.
- Keeps a sticky overflow flag and an operation counter for software status.

Parameters:
SIZE, 4, operand width; must equal the alu's SIZE; result width is 2*SIZE.
DEPTH, 4, request FIFO entries; power of 2, >= 2.
CNT_W, 16, operation counter width.

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request FIFO can accept
req_cmd  in  4  alu command code (0x0..0xC legal)
req_a  in  SIZE  operand a
req_b  in  SIZE  operand b
alu_enable  out  1  to alu enable
alu_command  out  4  to alu command
alu_a  out  SIZE  to alu a
alu_b  out  SIZE  to alu b
alu_overflow  in  1  from alu overflow
alu_result  in  2*SIZE  from alu result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  2*SIZE  captured result
rsp_overflow  out  1  captured overflow
rsp_err  out  1  request had illegal command
clr_status  in  1  one-cycle pulse; clears ovf_sticky
ovf_sticky  out  1  set by any accepted response with overflow=1
op_count  out  CNT_W  count of response handshakes; wraps

Behaviour:
Reset (rst_n=0 at rising edge):
- FIFO emptied; state=IDLE.
- All outputs 0: alu_*, rsp_*, ovf_sticky, op_count.
- req_ready is forced 0 while rst_n=0.
- Reset mid-operation drops in-flight and queued requests; no response is produced for them.

Request side:
- Accept on req_valid & req_ready; push {cmd,a,b}.
- req_ready = !full.
- Simultaneous push and pop when full: push is refused (req_ready already 0). Pop frees the slot next cycle.

FSM states: IDLE, EXEC, RESP.
- IDLE: if FIFO non-empty, pop at the edge, load alu_command/alu_a/alu_b, set alu_enable=1, go EXEC.
- EXEC (exactly 1 cycle): alu is combinational. At the closing edge, load rsp_result=alu_result, rsp_overflow=alu_overflow, rsp_err=0, clear alu_enable, set rsp_valid=1, go RESP.
- Illegal cmd (>0xC) popped in IDLE:
  - alu_enable stays 0 and no EXEC cycle occurs.
  - Go directly to RESP with rsp_err=1, rsp_result=0, rsp_overflow=0.
- RESP: hold all rsp_* stable while rsp_ready=0. On rsp_valid & rsp_ready:
  - If FIFO non-empty, pop and go EXEC (or RESP for an illegal cmd) at the same edge; rsp_valid is 0 for the EXEC cycle.
  - Otherwise go IDLE with rsp_valid=0.

Timing:
- alu_command/alu_a/alu_b hold their last values outside EXEC; only alu_enable toggles.
- Latency, empty pipe: request accepted at edge E0 -> EXEC during cycle after E1 -> rsp_valid=1 after E2.
- Sustained throughput: 1 op per 2 cycles with rsp_ready=1.

Status:
- op_count increments on every response handshake, including err responses; wraps 2^CNT_W-1 -> 0.
- ovf_sticky is set on a handshake with rsp_overflow=1 and cleared by clr_status. Set and clear in the same cycle: set wins.

Decomposition:
- Package alu_pkg holds:
  - command constants: ALU_AND=0, ALU_OR=1, ALU_XOR=2, ALU_NOT=3, ALU_UADD=4, ALU_SADD=5, ALU_USUB=6, ALU_SSUB=7, ALU_UMUL=8, ALU_SMUL=9, ALU_UCMP=A, ALU_SCMP=B, ALU_SHIFT=C, ALU_CMD_LAST=C;
  - FSM state enum;
  - function alu_cmd_legal().
- One sub-module: alu_req_fifo, a synchronous FIFO parameterised by width and DEPTH, with push/pop/full/empty.
- alu_issue_ctrl instantiates the FIFO; the testbench instantiates alu_issue_ctrl together with alu.

Test Plan:
- Single op, rsp_ready=1, SIZE=4: cmd=4, a=F, b=1 -> alu_enable high for exactly 1 cycle; rsp_valid 2 edges after acceptance; rsp_result=0x00, rsp_overflow=1, ovf_sticky=1, op_count=1.
- Back-to-back stream: {0,A,5}, {8,7,8}, {9,E,B}, {B,A,F} -> responses in order: 0x00/0; 0x38/1; 0x0A/1; 0x00/0; one response every 2 cycles; op_count=4.
- Backpressure: rsp_ready=0, push 6 requests -> req_ready drops after FIFO fills (DEPTH=4 queued, 1 in RESP); rsp_* stable while held; releasing rsp_ready drains all in order.
- Illegal command: cmd=E, a=3, b=3 -> alu_enable never asserts; rsp_err=1, rsp_result=0, rsp_overflow=0; op_count increments.
- Status: clr_status asserted in the same cycle as a handshake with overflow=1 -> ovf_sticky=1. A clr_status alone next cycle -> ovf_sticky=0.
- Reset mid-op: rst_n=0 for 1 cycle during EXEC with 2 queued -> all outputs 0, state IDLE, no stale responses afterward; a new request behaves as in scenario 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared alu command codes, issue FSM states and command legality check
// for the alu issue/sequencing slice.
package alu_pkg;

  localparam logic [3:0] ALU_AND      = 4'h0;
  localparam logic [3:0] ALU_OR       = 4'h1;
  localparam logic [3:0] ALU_XOR      = 4'h2;
  localparam logic [3:0] ALU_NOT      = 4'h3;
  localparam logic [3:0] ALU_UADD     = 4'h4;
  localparam logic [3:0] ALU_SADD     = 4'h5;
  localparam logic [3:0] ALU_USUB     = 4'h6;
  localparam logic [3:0] ALU_SSUB     = 4'h7;
  localparam logic [3:0] ALU_UMUL     = 4'h8;
  localparam logic [3:0] ALU_SMUL     = 4'h9;
  localparam logic [3:0] ALU_UCMP     = 4'hA;
  localparam logic [3:0] ALU_SCMP     = 4'hB;
  localparam logic [3:0] ALU_SHIFT    = 4'hC;
  localparam logic [3:0] ALU_CMD_LAST = 4'hC;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } issue_state_t;

  function automatic logic alu_cmd_legal(input logic [3:0] cmd);
    return cmd <= ALU_CMD_LAST;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, alu-drive and response signal bundle of the issue stage.
// slave is the issue controller's view; master is the surrounding system's view.
interface alu_issue_ctrl_if #(
  parameter int unsigned SIZE = 4
);
  logic                req_valid;
  logic                req_ready;
  logic [3:0]          req_cmd;
  logic [SIZE-1:0]     req_a;
  logic [SIZE-1:0]     req_b;

  logic                alu_enable;
  logic [3:0]          alu_command;
  logic [SIZE-1:0]     alu_a;
  logic [SIZE-1:0]     alu_b;
  logic                alu_overflow;
  logic [2*SIZE-1:0]   alu_result;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [2*SIZE-1:0]   rsp_result;
  logic                rsp_overflow;
  logic                rsp_err;

  modport slave (
    input  req_valid, req_cmd, req_a, req_b,
    output req_ready,
    output alu_enable, alu_command, alu_a, alu_b,
    input  alu_overflow, alu_result,
    output rsp_valid, rsp_result, rsp_overflow, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_cmd, req_a, req_b,
    input  req_ready,
    input  alu_enable, alu_command, alu_a, alu_b,
    output alu_overflow, alu_result,
    input  rsp_valid, rsp_result, rsp_overflow, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu.sv
// Combinational alu. Add/sub results are SIZE bits zero-extended with carry/borrow
// or signed overflow flagged; products are full width, overflow when not SIZE-representable.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic              enable,
  input  logic [3:0]        command,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              overflow,
  output logic [2*SIZE-1:0] result
);

  logic        [SIZE:0]     usum;
  logic        [SIZE:0]     udif;
  logic signed [SIZE:0]     ssum;
  logic signed [SIZE:0]     sdif;
  logic        [2*SIZE-1:0] uprod;
  logic signed [2*SIZE-1:0] sprod;
  logic        [SIZE:0]     sprod_hi;

  assign usum     = {1'b0, a} + {1'b0, b};
  assign udif     = {1'b0, a} - {1'b0, b};
  assign ssum     = $signed({a[SIZE-1], a}) + $signed({b[SIZE-1], b});
  assign sdif     = $signed({a[SIZE-1], a}) - $signed({b[SIZE-1], b});
  assign uprod    = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};
  assign sprod    = $signed({{SIZE{a[SIZE-1]}}, a}) * $signed({{SIZE{b[SIZE-1]}}, b});
  assign sprod_hi = sprod[2*SIZE-1:SIZE-1];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    if (enable) begin
      case (command)
        ALU_AND:   result = {{SIZE{1'b0}}, a & b};
        ALU_OR:    result = {{SIZE{1'b0}}, a | b};
        ALU_XOR:   result = {{SIZE{1'b0}}, a ^ b};
        ALU_NOT:   result = {{SIZE{1'b0}}, ~a};
        ALU_UADD: begin
          result   = {{SIZE{1'b0}}, usum[SIZE-1:0]};
          overflow = usum[SIZE];
        end
        ALU_SADD: begin
          result   = {{SIZE{1'b0}}, ssum[SIZE-1:0]};
          overflow = ssum[SIZE] ^ ssum[SIZE-1];
        end
        ALU_USUB: begin
          result   = {{SIZE{1'b0}}, udif[SIZE-1:0]};
          overflow = udif[SIZE];
        end
        ALU_SSUB: begin
          result   = {{SIZE{1'b0}}, sdif[SIZE-1:0]};
          overflow = sdif[SIZE] ^ sdif[SIZE-1];
        end
        ALU_UMUL: begin
          result   = uprod;
          overflow = |uprod[2*SIZE-1:SIZE];
        end
        ALU_SMUL: begin
          // Representable in SIZE signed bits only if the top SIZE+1 bits agree.
          result   = sprod;
          overflow = !((&sprod_hi) || !(|sprod_hi));
        end
        ALU_UCMP:  result = {{(2*SIZE-1){1'b0}}, a > b};
        ALU_SCMP:  result = {{(2*SIZE-1){1'b0}}, $signed(a) > $signed(b)};
        ALU_SHIFT: result = {{SIZE{1'b0}}, a} << b;
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/alu_req_fifo.sv
// Synchronous show-ahead FIFO holding queued alu requests.
// A push while full is dropped even when a pop occurs in the same cycle.
module alu_req_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage ahead of the combinational alu: queues requests, drives the alu for
// one cycle per legal op, captures the result and keeps overflow/op-count status.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  bus,
  input  logic             clr_status,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned FW = 4 + 2*SIZE;

  issue_state_t    state;
  logic [FW-1:0]   head;
  logic [3:0]      head_cmd;
  logic [SIZE-1:0] head_a;
  logic [SIZE-1:0] head_b;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            rsp_hs;

  assign bus.req_ready = rst_n && !full;
  assign push          = bus.req_valid && bus.req_ready;
  assign rsp_hs        = bus.rsp_valid && bus.rsp_ready;
  // The next request is taken either from idle or in the same edge as a response handshake.
  assign pop           = !empty && ((state == IDLE) || ((state == RESP) && rsp_hs));
  assign {head_cmd, head_a, head_b} = head;

  alu_req_fifo #(
    .WIDTH(FW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({bus.req_cmd, bus.req_a, bus.req_b}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      bus.alu_enable   <= 1'b0;
      bus.alu_command  <= '0;
      bus.alu_a        <= '0;
      bus.alu_b        <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_result   <= '0;
      bus.rsp_overflow <= 1'b0;
      bus.rsp_err      <= 1'b0;
      ovf_sticky       <= 1'b0;
      op_count         <= '0;
    end else begin
      if (rsp_hs) begin
        op_count <= op_count + CNT_W'(1);
      end
      if (rsp_hs && bus.rsp_overflow) begin
        ovf_sticky <= 1'b1;
      end else if (clr_status) begin
        ovf_sticky <= 1'b0;
      end

      if (pop) begin
        if (alu_cmd_legal(head_cmd)) begin
          bus.alu_enable  <= 1'b1;
          bus.alu_command <= head_cmd;
          bus.alu_a       <= head_a;
          bus.alu_b       <= head_b;
          bus.rsp_valid   <= 1'b0;
          state           <= EXEC;
        end else begin
          // Illegal commands never reach the alu; answer with an error response.
          bus.rsp_valid    <= 1'b1;
          bus.rsp_result   <= '0;
          bus.rsp_overflow <= 1'b0;
          bus.rsp_err      <= 1'b1;
          state            <= RESP;
        end
      end else begin
        case (state)
          EXEC: begin
            bus.alu_enable   <= 1'b0;
            bus.rsp_result   <= bus.alu_result;
            bus.rsp_overflow <= bus.alu_overflow;
            bus.rsp_err      <= 1'b0;
            bus.rsp_valid    <= 1'b1;
            state            <= RESP;
          end
          RESP: begin
            if (bus.rsp_ready) begin
              bus.rsp_valid <= 1'b0;
              state         <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
